// File: rtl/pdm_playback_engine.sv
// Sample-buffer playback engine: fetches signed samples from an external buffer
// in forward/reverse/hold/mute order and converts them to a 1-bit PDM stream.
module pdm_playback_engine #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned CLK_DIV = 32,
  parameter int unsigned OSR     = 64
) (
  input  logic              sysclk,
  input  logic              sysreset_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] loop_len,
  input  logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] read_address,
  output logic              rd_en,
  output logic              sample_valid,
  output logic              pdm_out
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (OSR > 1) ? $clog2(OSR) : 1;

  localparam logic [1:0] MODE_MUTE = 2'b00;
  localparam logic [1:0] MODE_FWD  = 2'b01;
  localparam logic [1:0] MODE_REV  = 2'b10;

  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W:0]   acc;
  logic [DATA_W-1:0] sample_reg;

  logic              tick_c;
  logic              last_bit_c;
  logic [DATA_W-1:0] offset_c;
  logic [DATA_W:0]   acc_next_c;
  logic [ADDR_W:0]   addr_inc_c;
  logic [ADDR_W-1:0] addr_next_c;

  assign tick_c     = enable && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_bit_c = (bit_cnt == BIT_W'(OSR - 1));

  // Signed sample mapped to offset binary so the carry density tracks amplitude.
  assign offset_c   = {~sample_reg[DATA_W-1], sample_reg[DATA_W-2:0]};
  assign acc_next_c = {1'b0, acc[DATA_W-1:0]} + {1'b0, offset_c};
  assign addr_inc_c = {1'b0, read_address} + (ADDR_W + 1)'(1);

  // The carry of the last accumulator update is the PDM bit.
  assign pdm_out = acc[DATA_W];

  // Next buffer address, evaluated only at the sample boundary.
  always_comb begin
    addr_next_c = read_address;
    if (loop_len <= ADDR_W'(1)) begin
      addr_next_c = '0;
    end else begin
      case (mode)
        MODE_FWD: begin
          if (addr_inc_c >= {1'b0, loop_len}) addr_next_c = '0;
          else                                addr_next_c = addr_inc_c[ADDR_W-1:0];
        end
        MODE_REV: begin
          if ((read_address == '0) || (read_address >= loop_len))
            addr_next_c = loop_len - ADDR_W'(1);
          else
            addr_next_c = read_address - ADDR_W'(1);
        end
        default: addr_next_c = read_address;
      endcase
    end
  end

  // Bit clock divider and bit counter.
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      if (enable) begin
        if (tick_c) div_cnt <= '0;
        else        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (tick_c) begin
        if (last_bit_c) bit_cnt <= '0;
        else            bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  // First-order sigma-delta accumulator.
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      acc <= '0;
    end else if (tick_c) begin
      acc <= acc_next_c;
    end
  end

  // Buffer read handshake; a read already issued completes even if enable drops.
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      rd_en        <= 1'b0;
      sample_valid <= 1'b0;
      sample_reg   <= '0;
      read_address <= '0;
    end else begin
      rd_en        <= tick_c && last_bit_c;
      sample_valid <= rd_en;
      if (sample_valid) begin
        sample_reg   <= (mode == MODE_MUTE) ? '0 : data_in;
        read_address <= addr_next_c;
      end
    end
  end

endmodule

// File: tb/tb_pdm_playback_engine.sv
// Directed self-checking bench for pdm_playback_engine (CLK_DIV=4, OSR=8).
module tb_pdm_playback_engine;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned OSR     = 8;

  logic              sysclk = 1'b0;
  logic              sysreset_n;
  logic              enable;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] loop_len;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] read_address;
  logic              rd_en;
  logic              sample_valid;
  logic              pdm_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  pdm_playback_engine #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CLK_DIV(CLK_DIV),
    .OSR    (OSR)
  ) dut (
    .sysclk      (sysclk),
    .sysreset_n  (sysreset_n),
    .enable      (enable),
    .mode        (mode),
    .loop_len    (loop_len),
    .data_in     (data_in),
    .read_address(read_address),
    .rd_en       (rd_en),
    .sample_valid(sample_valid),
    .pdm_out     (pdm_out)
  );

  always #5 sysclk = ~sysclk;

  // One clock; cyc counts edges seen with the engine enabled and out of reset.
  task automatic step();
    @(posedge sysclk);
    #1;
    if (enable && sysreset_n) cyc++;
  endtask

  task automatic run_to(input int target);
    int budget;
    budget = 0;
    while (cyc < target && budget < 5000) begin
      step();
      budget++;
    end
    if (cyc < target) begin
      checks++;
      errors++;
      $display("FAIL run_to timeout: cyc %0d required %0d", cyc, target);
    end
  endtask

  task automatic apply_reset();
    sysreset_n = 1'b0;
    enable     = 1'b0;
    mode       = 2'b00;
    loop_len   = '0;
    data_in    = '0;
    step();
    step();
    sysreset_n = 1'b1;
    step();
    cyc = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (read_address !== 4'd0) begin errors++; $display("FAIL reset_addr got %0h exp 0", read_address); end
    checks++;
    if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", rd_en); end
    checks++;
    if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_sv got %b exp 0", sample_valid); end
    checks++;
    if (pdm_out !== 1'b0) begin errors++; $display("FAIL reset_pdm got %b exp 0", pdm_out); end
  endtask

  task automatic test_forward();
    logic [ADDR_W-1:0] exp_addr [5];
    exp_addr = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    apply_reset();
    mode = 2'b01; loop_len = 4'd4; data_in = 16'h0000; enable = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      run_to(4 * t);
      checks++;
      if (pdm_out !== logic'(t % 2 == 0)) begin
        errors++; $display("FAIL fwd_pdm tick %0d got %b exp %b", t, pdm_out, (t % 2 == 0));
      end
    end
    for (int k = 0; k < 5; k++) begin
      run_to(32 * (k + 1) - 1);
      checks++;
      if (rd_en !== 1'b0) begin errors++; $display("FAIL fwd_rd_early %0d got %b exp 0", k, rd_en); end
      step();
      checks++;
      if (rd_en !== 1'b1 || read_address !== exp_addr[k]) begin
        errors++; $display("FAIL fwd_addr %0d got rd_en %b addr %0d exp 1 %0d", k, rd_en, read_address, exp_addr[k]);
      end
      step();
      checks++;
      if (sample_valid !== 1'b1 || rd_en !== 1'b0) begin
        errors++; $display("FAIL fwd_sv %0d got sv %b rd %b exp 1 0", k, sample_valid, rd_en);
      end
      step();
      checks++;
      if (sample_valid !== 1'b0) begin errors++; $display("FAIL fwd_sv_pulse %0d got %b exp 0", k, sample_valid); end
    end
  endtask

  task automatic test_reverse();
    logic [ADDR_W-1:0] exp_addr [5];
    exp_addr = '{4'd0, 4'd3, 4'd2, 4'd1, 4'd0};
    apply_reset();
    mode = 2'b10; loop_len = 4'd4; data_in = 16'h0000; enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      run_to(32 * (k + 1));
      checks++;
      if (rd_en !== 1'b1 || read_address !== exp_addr[k]) begin
        errors++; $display("FAIL rev_addr %0d got rd_en %b addr %0d exp 1 %0d", k, rd_en, read_address, exp_addr[k]);
      end
    end
  endtask

  task automatic test_short_loop();
    apply_reset();
    mode = 2'b01; loop_len = 4'd1; data_in = 16'h0000; enable = 1'b1;
    run_to(32);
    run_to(64);
    checks++;
    if (rd_en !== 1'b1 || read_address !== 4'd0) begin
      errors++; $display("FAIL len1_fwd got rd_en %b addr %0d exp 1 0", rd_en, read_address);
    end
    run_to(70);
    mode = 2'b10; loop_len = 4'd0;
    run_to(96);
    checks++;
    if (rd_en !== 1'b1 || read_address !== 4'd0) begin
      errors++; $display("FAIL len0_rev got rd_en %b addr %0d exp 1 0", rd_en, read_address);
    end
  endtask

  task automatic test_density();
    int ones;
    apply_reset();
    mode = 2'b01; loop_len = 4'd4; data_in = 16'h7FFF; enable = 1'b1;
    ones = 0;
    for (int t = 9; t <= 16; t++) begin run_to(4 * t); ones += int'(pdm_out); end
    checks++;
    if (ones != 7) begin errors++; $display("FAIL dens_7fff_first got %0d ones exp 7", ones); end
    ones = 0;
    for (int t = 17; t <= 24; t++) begin run_to(4 * t); ones += int'(pdm_out); end
    checks++;
    if (ones != 8) begin errors++; $display("FAIL dens_7fff_steady got %0d ones exp 8", ones); end

    apply_reset();
    mode = 2'b01; loop_len = 4'd4; data_in = 16'h8000; enable = 1'b1;
    ones = 0;
    for (int t = 9; t <= 24; t++) begin run_to(4 * t); ones += int'(pdm_out); end
    checks++;
    if (ones != 0) begin errors++; $display("FAIL dens_8000 got %0d ones exp 0", ones); end
  endtask

  task automatic test_mode_change();
    int ones;
    apply_reset();
    mode = 2'b01; loop_len = 4'd4; data_in = 16'h0000; enable = 1'b1;
    run_to(40);
    mode = 2'b11;
    run_to(64);
    checks++;
    if (rd_en !== 1'b1 || read_address !== 4'd1) begin
      errors++; $display("FAIL hold_step got rd_en %b addr %0d exp 1 1", rd_en, read_address);
    end
    run_to(96);
    checks++;
    if (rd_en !== 1'b1 || read_address !== 4'd1) begin
      errors++; $display("FAIL hold_keep got rd_en %b addr %0d exp 1 1", rd_en, read_address);
    end
    run_to(100);
    mode = 2'b00; data_in = 16'h7FFF;
    run_to(128);
    checks++;
    if (rd_en !== 1'b1 || read_address !== 4'd1) begin
      errors++; $display("FAIL mute_rd got rd_en %b addr %0d exp 1 1", rd_en, read_address);
    end
    ones = 0;
    for (int t = 33; t <= 40; t++) begin run_to(4 * t); ones += int'(pdm_out); end
    checks++;
    if (ones != 4) begin errors++; $display("FAIL mute_density got %0d ones exp 4", ones); end
    checks++;
    if (rd_en !== 1'b1 || read_address !== 4'd1) begin
      errors++; $display("FAIL mute_addr got rd_en %b addr %0d exp 1 1", rd_en, read_address);
    end
  endtask

  task automatic test_enable_freeze();
    apply_reset();
    mode = 2'b01; loop_len = 4'd4; data_in = 16'h0000; enable = 1'b1;
    run_to(41);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (rd_en !== 1'b0 || sample_valid !== 1'b0 || pdm_out !== 1'b1) begin
        errors++; $display("FAIL freeze %0d got rd %b sv %b pdm %b exp 0 0 1", i, rd_en, sample_valid, pdm_out);
      end
    end
    enable = 1'b1;
    run_to(43);
    checks++;
    if (pdm_out !== 1'b1) begin errors++; $display("FAIL resume_pre got pdm %b exp 1", pdm_out); end
    step();
    checks++;
    if (pdm_out !== 1'b0) begin errors++; $display("FAIL resume_tick got pdm %b exp 0", pdm_out); end
    run_to(63);
    checks++;
    if (rd_en !== 1'b0) begin errors++; $display("FAIL resume_rd_early got %b exp 0", rd_en); end
    step();
    checks++;
    if (rd_en !== 1'b1 || read_address !== 4'd1) begin
      errors++; $display("FAIL resume_rd got rd_en %b addr %0d exp 1 1", rd_en, read_address);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    mode = 2'b01; loop_len = 4'd4; data_in = 16'h1234; enable = 1'b1;
    run_to(32);
    #2;
    sysreset_n = 1'b0;
    #1;
    checks++;
    if (rd_en !== 1'b0 || sample_valid !== 1'b0 || pdm_out !== 1'b0 || read_address !== 4'd0) begin
      errors++; $display("FAIL async_reset got rd %b sv %b pdm %b addr %0d exp 0 0 0 0",
                         rd_en, sample_valid, pdm_out, read_address);
    end
    step();
    step();
    sysreset_n = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++;
      if (rd_en !== 1'b0 || sample_valid !== 1'b0) begin
        errors++; $display("FAIL post_reset %0d got rd %b sv %b exp 0 0", i, rd_en, sample_valid);
      end
      if (cyc == 7) begin
        checks++;
        if (pdm_out !== 1'b0) begin errors++; $display("FAIL post_reset_pdm7 got %b exp 0", pdm_out); end
      end
      if (cyc == 8) begin
        checks++;
        if (pdm_out !== 1'b1) begin errors++; $display("FAIL post_reset_pdm8 got %b exp 1", pdm_out); end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    sysreset_n = 1'b0;
    enable     = 1'b0;
    mode       = 2'b00;
    loop_len   = '0;
    data_in    = '0;
    test_reset();
    test_forward();
    test_reverse();
    test_short_loop();
    test_density();
    test_mode_change();
    test_enable_freeze();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_playback_engine.md
PDM_PLAYBACK_ENGINE -- requirements
Module: pdm_playback_engine

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_W, default 16: signed sample width.
REQ-003 Parameter ADDR_W, default 16: buffer address width.
REQ-004 Parameter CLK_DIV, default 32: sysclk cycles per PDM bit; minimum 3.
REQ-005 Parameter OSR, default 64: PDM bits per sample; minimum 2.
REQ-006 Port sysclk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-007 Port sysreset_n, input, 1 bit: asynchronous active-low reset.
REQ-008 Port enable, input, 1 bit: run (1) or freeze (0).
REQ-009 Port mode, input, 2 bits: 00 mute, 01 forward, 10 reverse, 11 hold.
REQ-010 Port loop_len, input, ADDR_W bits: number of buffer entries in the playback loop.
REQ-011 Port data_in, input, DATA_W bits: signed sample from the buffer; valid 1 cycle after rd_en.
REQ-012 Port read_address, output, ADDR_W bits: buffer read address.
REQ-013 Port rd_en, output, 1 bit: one-cycle buffer read strobe.
REQ-014 Port sample_valid, output, 1 bit: one-cycle pulse when a new sample is latched.
REQ-015 Port pdm_out, output, 1 bit: registered PDM audio bitstream.

Function
REQ-016 Divider div_cnt SHALL count 0..CLK_DIV-1 while enable=1; tick is high for the cycle in which div_cnt=CLK_DIV-1.
REQ-017 bit_cnt SHALL count 0..OSR-1, advancing on tick and wrapping to 0 after OSR-1.
REQ-018 On each tick, acc (DATA_W+1 bits) SHALL become acc[DATA_W-1:0] + offset sample, where offset sample = sample_reg with its MSB inverted.
REQ-019 On each tick, pdm_out SHALL register the carry bit acc[DATA_W] produced by the REQ-018 update, so it changes only on ticks.
REQ-020 On the tick where bit_cnt=OSR-1, the block SHALL assert rd_en for exactly one cycle, with read_address holding the current address.
REQ-021 The cycle after rd_en, the block SHALL latch data_in into sample_reg and pulse sample_valid for one cycle; the new sample applies from the next tick onward.
REQ-022 In the sample_valid cycle, read_address SHALL update per mode, sampled at that cycle:
- 01 forward: addr+1, wrapping to 0 when addr+1 >= loop_len.
- 10 reverse: addr-1; from 0, or when addr >= loop_len, wrap to loop_len-1.
- 11 hold: address unchanged.
- 00 mute: address unchanged.
REQ-023 In mode 00, sample_reg SHALL be loaded with 0 instead of data_in, giving a 50% density output; rd_en still pulses.
REQ-024 loop_len=0 or loop_len=1 SHALL pin read_address at 0.
REQ-025 Changes to mode and loop_len between sample boundaries SHALL have no effect until the next sample_valid cycle.
REQ-026 enable=0 SHALL freeze div_cnt, bit_cnt, acc, address and sample_reg, force rd_en and sample_valid low, and hold pdm_out at its last value.
REQ-027 If enable falls in the rd_en cycle, the latch SHALL still complete in the following cycle.
REQ-028 Arithmetic SHALL be unsigned modular within the stated widths; no saturation.

Reset
REQ-029 Asserting sysreset_n low SHALL immediately clear div_cnt, bit_cnt, acc, sample_reg, read_address, rd_en, sample_valid and pdm_out to 0.
REQ-030 Reset asserted mid-sample SHALL discard any pending read.
REQ-031 After reset release, the first tick SHALL occur CLK_DIV cycles after enable is seen high.

Verification (CLK_DIV=4, OSR=8, DATA_W=16, ADDR_W=4)
REQ-032 Reset then enable=1, mode=01, loop_len=4, data_in=0x0000:
- pdm_out toggles 0,1,0,1 on successive ticks.
- rd_en pulses every 32 cycles.
- read_address sequence 0,1,2,3,0.
REQ-033 mode=10, loop_len=4, starting from address 0: read_address sequence 0,3,2,1,0.
REQ-034 data_in=0x7FFF: pdm_out density is at least 7 ones per 8 ticks; data_in=0x8000: pdm_out is all zero after the first sample.
REQ-035 mode changed 01->11 mid-sample: the address keeps its pending forward step once, then holds; mode=00: sample_reg=0 and the address is frozen.
REQ-036 enable dropped for 10 cycles mid-bit: no tick, rd_en or sample_valid occurs, and the tick phase resumes unchanged. sysreset_n pulsed low mid-sample: all outputs read 0 in the same cycle, with no stray sample_valid afterwards.
